// File: rtl/softmax_pkg.sv
// Shared types and helpers for the softmax exp sequencer: FSM encoding,
// float field widths and a sign-magnitude greater-than compare.
package softmax_pkg;

  localparam int FP_E = 8;
  localparam int FP_M = 23;
  localparam int FP_W = 1 + FP_E + FP_M;

  typedef enum logic [1:0] {
    S_LOAD,
    S_ISSUE,
    S_WAIT,
    S_EMIT
  } state_t;

  // Words are zero-extended to 64 bits; w is the real float width.
  // +0/-0 compare equal, NaN bit patterns are ordered like any other value.
  function automatic logic float_gt(input logic [63:0] a, input logic [63:0] b,
                                    input int w);
    logic [63:0] sbit, mask, ma, mb;
    logic        sa, sb;
    sbit = 64'd1 << (w - 1);
    mask = sbit - 64'd1;
    ma   = a & mask;
    mb   = b & mask;
    sa   = |(a & sbit);
    sb   = |(b & sbit);
    if (ma == 64'd0 && mb == 64'd0) return 1'b0;
    if (sa != sb) return sb;
    if (!sa) return ma > mb;
    return ma < mb;
  endfunction

endpackage

// File: rtl/softmax_vec_buffer.sv
// Vector storage for one softmax vector: single write port, async read port.
module softmax_vec_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem;

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];

endmodule

// File: rtl/softmax_exp_sequencer.sv
// Collects one softmax vector, tracks its max, then feeds elements one at a
// time to the exp stage and streams the results out with index/last tags.
module softmax_exp_sequencer
  import softmax_pkg::*;
#(
  parameter int DATA_WIDTH = FP_W,
  parameter int E          = FP_E,
  parameter int M          = FP_M,
  parameter int VEC_LEN    = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [DATA_WIDTH-1:0]      in_data,
  output logic                       in_ready,
  output logic                       start_exp,
  output logic [DATA_WIDTH-1:0]      exp_x,
  input  logic [DATA_WIDTH-1:0]      exp_result,
  input  logic                       exp_done,
  output logic                       out_valid,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic [$clog2(VEC_LEN)-1:0] out_index,
  output logic                       out_last,
  input  logic                       out_ready,
  output logic [DATA_WIDTH-1:0]      max_value,
  output logic                       busy,
  output logic                       timeout_err
);

  localparam int              AW       = $clog2(VEC_LEN);
  localparam int              TW       = $clog2(TIMEOUT + 1);
  localparam logic [AW-1:0]   LAST_IDX = AW'(VEC_LEN - 1);
  localparam logic [TW-1:0]   TMR_MAX  = TW'(TIMEOUT);

  state_t                  state, state_nx;
  logic [AW-1:0]           wr_cnt, rd_cnt;
  logic [TW-1:0]           tmr;
  logic [DATA_WIDTH-1:0]   rd_data;
  logic                    load_fire, emit_fire;

  softmax_vec_buffer #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (VEC_LEN),
    .AW        (AW)
  ) u_buf (
    .clk  (clk),
    .we   (load_fire),
    .waddr(wr_cnt),
    .wdata(in_data),
    .raddr(rd_cnt),
    .rdata(rd_data)
  );

  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= S_LOAD;
    else        state <= state_nx;

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    start_exp = 1'b0;
    case (state)
      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid && wr_cnt == LAST_IDX) state_nx = S_ISSUE;
      end
      S_ISSUE: begin
        start_exp = 1'b1;
        state_nx  = S_WAIT;
      end
      S_WAIT: begin
        if (exp_done)            state_nx = S_EMIT;
        else if (tmr == TMR_MAX) state_nx = S_LOAD;
      end
      S_EMIT: begin
        if (out_ready) state_nx = (rd_cnt == LAST_IDX) ? S_LOAD : S_ISSUE;
      end
      default: state_nx = S_LOAD;
    endcase
  end

  assign busy      = (state != S_LOAD);
  assign load_fire = in_ready && in_valid;
  assign emit_fire = (state == S_EMIT) && out_valid && out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_cnt      <= '0;
      rd_cnt      <= '0;
      tmr         <= '0;
      exp_x       <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_index   <= '0;
      out_last    <= 1'b0;
      max_value   <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (load_fire) begin
        wr_cnt <= (wr_cnt == LAST_IDX) ? '0 : wr_cnt + 1'b1;
        // Strict compare keeps the earlier element on ties.
        if (wr_cnt == '0 || float_gt(64'(in_data), 64'(max_value), 1 + E + M))
          max_value <= in_data;
      end
      if (state == S_ISSUE) begin
        exp_x <= rd_data;
        tmr   <= '0;
      end
      if (state == S_WAIT) begin
        tmr <= tmr + 1'b1;
        if (exp_done) begin
          out_data  <= exp_result;
          out_valid <= 1'b1;
          out_index <= rd_cnt;
          out_last  <= (rd_cnt == LAST_IDX);
        end else if (tmr == TMR_MAX) begin
          // Abandon the remainder of this vector.
          timeout_err <= 1'b1;
          rd_cnt      <= '0;
        end
      end
      if (emit_fire) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
        rd_cnt    <= (rd_cnt == LAST_IDX) ? '0 : rd_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_softmax_exp_sequencer.sv
// Directed bench for softmax_exp_sequencer with a fixed-latency exp model
// and a scoreboard of expected output beats.
module tb_softmax_exp_sequencer;

  localparam int          TIMEOUT = 20;
  localparam int          EXP_LAT = 5;
  localparam logic [31:0] KEY     = 32'h5A5A_5A5A;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  idx;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, in_valid, out_ready;
  logic [31:0] in_data;
  logic        in_ready, start_exp, out_valid, out_last, busy, timeout_err;
  logic [31:0] exp_x, out_data, max_value;
  logic [1:0]  out_index;
  logic [31:0] exp_result = 32'd0;
  logic        exp_done   = 1'b0;

  logic        exp_en = 1'b1;
  logic        gap_en = 1'b0;
  int          n_assert = 0, n_fail = 0;
  int          n_start = 0, prev_start = 0, cyc = 0;
  exp_t        sb_q[$];

  softmax_exp_sequencer #(
    .DATA_WIDTH(32), .E(8), .M(23), .VEC_LEN(4), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .start_exp(start_exp), .exp_x(exp_x),
    .exp_result(exp_result), .exp_done(exp_done), .out_valid(out_valid),
    .out_data(out_data), .out_index(out_index), .out_last(out_last),
    .out_ready(out_ready), .max_value(max_value), .busy(busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0][31:0] vec4(input logic [31:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  // Exp stage stand-in: done pulse EXP_LAT cycles after the start cycle.
  always begin
    @(negedge clk);
    if (reset && exp_en && start_exp) begin
      repeat (EXP_LAT) @(posedge clk);
      #1 exp_done = 1'b1;
      exp_result = exp_x ^ KEY;
      @(posedge clk);
      #1 exp_done = 1'b0;
    end
  end

  // Output scoreboard and start pulse spacing.
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      if (sb_q.size() == 0) chk("unexpected_out", 32'(out_valid), 32'd0);
      else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("out_data", out_data, e.data);
        chk("out_index", 32'(out_index), 32'(e.idx));
        chk("out_last", 32'(out_last), 32'(e.last));
      end
    end
    if (reset && start_exp) begin
      if (gap_en && (n_start % 4) != 0) chk("start_gap", 32'(cyc - prev_start), 32'd7);
      prev_start = cyc;
      n_start++;
    end
  end

  task automatic load_vec(input logic [3:0][31:0] v, input int npush);
    int t;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = v[i];
      t = 0;
      while (!in_ready && t < 200) begin @(posedge clk); #1; t++; end
      chk("load_ready", 32'(in_ready), 32'd1);
      if (i < npush) sb_q.push_back('{v[i] ^ KEY, 2'(i), (i == 3)});
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    while ((sb_q.size() != 0 || busy) && t < 1000) begin @(posedge clk); #1; t++; end
    chk(tag, 32'(busy), 32'd0);
    chk({tag, "_sb"}, 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [3:0][31:0] v;
    int s0, t;
    reset = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_start", 32'(start_exp), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_tmo", 32'(timeout_err), 32'd0);
    chk("rst_exp_x", exp_x, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_index", 32'(out_index), 32'd0);
    chk("rst_max", max_value, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Mixed-sign vector, 7-cycle issue cadence.
    gap_en = 1'b1;
    s0 = n_start;
    v = vec4(32'h3F80_0000, 32'hC000_0000, 32'h4040_0000, 32'h3F00_0000);
    load_vec(v, 4);
    chk("t1_max", max_value, 32'h4040_0000);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_in_ready", 32'(in_ready), 32'd0);
    chk("t1_start", 32'(start_exp), 32'd1);
    drain("t1_drain");
    chk("t1_starts", 32'(n_start - s0), 32'd4);

    // All-negative: -0 wins; then +0 first is kept over later -0.
    v = vec4(32'hC000_0000, 32'hBF80_0000, 32'hC040_0000, 32'h8000_0000);
    load_vec(v, 4);
    chk("t3_max_neg0", max_value, 32'h8000_0000);
    drain("t3a_drain");
    v = vec4(32'h0000_0000, 32'hBF80_0000, 32'hC040_0000, 32'h8000_0000);
    load_vec(v, 4);
    chk("t3_max_pos0", max_value, 32'h0000_0000);
    drain("t3b_drain");
    gap_en = 1'b0;

    // Consumer stall on index 1.
    v = vec4(32'h3F00_0000, 32'h4000_0000, 32'h3E80_0000, 32'hBF00_0000);
    load_vec(v, 4);
    t = 0;
    while (!(out_valid && out_index == 2'd1) && t < 200) begin @(posedge clk); #1; t++; end
    out_ready = 1'b0;
    chk("t4_reach", 32'(out_index), 32'd1);
    repeat (10) begin
      @(posedge clk); #1;
      chk("t4_valid", 32'(out_valid), 32'd1);
      chk("t4_index", 32'(out_index), 32'd1);
      chk("t4_data", out_data, 32'h4000_0000 ^ KEY);
      chk("t4_start", 32'(start_exp), 32'd0);
      chk("t4_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    drain("t4_drain");

    // Exp stage never answers.
    exp_en = 1'b0;
    s0 = n_start;
    v = vec4(32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000);
    load_vec(v, 0);
    repeat (TIMEOUT + 1) @(posedge clk);
    #1;
    chk("t5_tmo_early", 32'(timeout_err), 32'd0);
    chk("t5_busy_early", 32'(busy), 32'd1);
    @(posedge clk); #1;
    chk("t5_tmo", 32'(timeout_err), 32'd1);
    chk("t5_in_ready", 32'(in_ready), 32'd1);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_out_valid", 32'(out_valid), 32'd0);
    chk("t5_starts", 32'(n_start - s0), 32'd1);
    exp_en = 1'b1;
    v = vec4(32'h4100_0000, 32'h3F80_0000, 32'hC100_0000, 32'h4110_0000);
    load_vec(v, 4);
    chk("t5_max", max_value, 32'h4110_0000);
    drain("t5_drain");
    chk("t5_sticky", 32'(timeout_err), 32'd1);

    // Reset during WAIT of index 2.
    s0 = n_start;
    v = vec4(32'h3F80_0000, 32'h3F00_0000, 32'h3E80_0000, 32'h3E00_0000);
    load_vec(v, 2);
    t = 0;
    while ((n_start - s0) < 3 && t < 200) begin @(posedge clk); #1; t++; end
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("t6_in_ready", 32'(in_ready), 32'd1);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_start", 32'(start_exp), 32'd0);
    chk("t6_out_valid", 32'(out_valid), 32'd0);
    chk("t6_out_last", 32'(out_last), 32'd0);
    chk("t6_tmo", 32'(timeout_err), 32'd0);
    chk("t6_exp_x", exp_x, 32'd0);
    chk("t6_out_data", out_data, 32'd0);
    chk("t6_out_index", 32'(out_index), 32'd0);
    chk("t6_max", max_value, 32'd0);
    chk("t6_sb", 32'(sb_q.size()), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("t6_idle_valid", 32'(out_valid), 32'd0);
    v = vec4(32'hBF80_0000, 32'h4000_0000, 32'h3F80_0000, 32'h4000_0000);
    load_vec(v, 4);
    chk("t6_max_tie", max_value, 32'h4000_0000);
    drain("t6_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
